// File: rtl/bp_be_commit_monitor.sv
// Multi-core commit-trace monitor: classifies commit events, keeps per-core counters,
// detects finish stores, runs a no-progress watchdog and queues trace records.
module bp_be_commit_monitor #(
  parameter int num_core_p        = 2,
  parameter int vaddr_width_p     = 39,
  parameter int instr_width_p     = 32,
  parameter int dword_width_p     = 64,
  parameter int cnt_width_p       = 32,
  parameter int fifo_els_p        = 8,
  parameter int watchdog_cycles_p = 1024,
  parameter logic [dword_width_p-1:0] finish_addr_p = 'hC00DEAD0,
  localparam int core_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_core_p-1:0]                  commit_v_i,
  input  logic [3*num_core_p-1:0]                commit_kind_i,
  input  logic [vaddr_width_p*num_core_p-1:0]    commit_pc_i,
  input  logic [instr_width_p*num_core_p-1:0]    commit_instr_i,
  input  logic [num_core_p-1:0]                  store_v_i,
  input  logic [dword_width_p*num_core_p-1:0]    store_addr_i,
  input  logic [dword_width_p*num_core_p-1:0]    store_data_i,
  output logic                                   trace_v_o,
  input  logic                                   trace_ready_i,
  output logic [core_w_lp-1:0]                   trace_core_o,
  output logic [2:0]                             trace_kind_o,
  output logic [vaddr_width_p-1:0]               trace_pc_o,
  output logic [instr_width_p-1:0]               trace_instr_o,
  output logic [cnt_width_p*num_core_p-1:0]      cmt_cnt_o,
  output logic [cnt_width_p*num_core_p-1:0]      bub_cnt_o,
  output logic [cnt_width_p-1:0]                 drop_cnt_o,
  output logic                                   done_o,
  output logic                                   pass_o,
  output logic                                   fail_o,
  output logic                                   err_o,
  output logic                                   timeout_o,
  output logic [15:0]                            test_num_o,
  output logic [core_w_lp-1:0]                   done_core_o
);
  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int wd_w_lp  = $clog2(watchdog_cycles_p + 1);

  logic [1:0]                  r_warm;
  logic [num_core_p-1:0]       r_booted;
  logic [core_w_lp-1:0]        r_rr_ptr;
  logic [cnt_width_p-1:0]      r_cmt [num_core_p];
  logic [cnt_width_p-1:0]      r_bub [num_core_p];
  logic [cnt_width_p-1:0]      r_drop;
  logic [wd_w_lp-1:0]          r_wd;
  logic                        r_done, r_pass, r_fail, r_err, r_timeout;
  logic [15:0]                 r_test_num;
  logic [core_w_lp-1:0]        r_done_core;
  logic [ptr_w_lp:0]           r_wr_ptr, r_rd_ptr;
  logic [core_w_lp-1:0]        r_mem_core  [fifo_els_p];
  logic [2:0]                  r_mem_kind  [fifo_els_p];
  logic [vaddr_width_p-1:0]    r_mem_pc    [fifo_els_p];
  logic [instr_width_p-1:0]    r_mem_instr [fifo_els_p];

  logic                        w_active;
  logic [num_core_p-1:0]       w_rec_req, w_cmt, w_bub, w_boot, w_fin;
  logic [cnt_width_p-1:0]      w_req_cnt, w_drop_inc;
  logic [cnt_width_p:0]        w_drop_sum;
  logic                        w_gnt_v;
  logic [core_w_lp-1:0]        w_gnt_id;
  logic [2:0]                  w_gnt_kind;
  logic [vaddr_width_p-1:0]    w_gnt_pc;
  logic [instr_width_p-1:0]    w_gnt_instr;
  logic                        w_fin_any;
  logic [core_w_lp-1:0]        w_fin_id;
  logic [31:0]                 w_fin_data;
  logic [ptr_w_lp:0]           w_occ;
  logic                        w_deq, w_full, w_enq;
  logic                        w_wd_hit;
  logic                        w_unused;

  assign w_active = (r_warm == 2'd3) && !r_done;

  always_comb begin
    w_rec_req   = '0;
    w_cmt       = '0;
    w_bub       = '0;
    w_boot      = '0;
    w_fin       = '0;
    w_req_cnt   = '0;
    for (int c = 0; c < num_core_p; c++) begin
      if (w_active && commit_v_i[c]) begin
        w_rec_req[c] = (commit_kind_i[3*c +: 3] <= 3'd3);
        w_boot[c]    = w_rec_req[c];
        w_cmt[c]     = (commit_kind_i[3*c +: 3] == 3'd0);
        w_bub[c]     = r_booted[c] && (commit_kind_i[3*c +: 3] >= 3'd4)
                       && (commit_kind_i[3*c +: 3] <= 3'd6);
        w_fin[c]     = w_cmt[c] && store_v_i[c]
                       && (store_addr_i[dword_width_p*c +: dword_width_p] == finish_addr_p);
      end
      w_req_cnt = w_req_cnt + cnt_width_p'(w_rec_req[c]);
    end
  end

  // Round-robin: search starts at the pointer and wraps; first requester wins.
  always_comb begin
    w_gnt_v     = 1'b0;
    w_gnt_id    = '0;
    w_gnt_kind  = '0;
    w_gnt_pc    = '0;
    w_gnt_instr = '0;
    for (int k = 0; k < num_core_p; k++) begin
      for (int c = 0; c < num_core_p; c++) begin
        if (!w_gnt_v && w_rec_req[c] && (c == (int'(r_rr_ptr) + k) % num_core_p)) begin
          w_gnt_v     = 1'b1;
          w_gnt_id    = core_w_lp'(c);
          w_gnt_kind  = commit_kind_i[3*c +: 3];
          w_gnt_pc    = commit_pc_i[vaddr_width_p*c +: vaddr_width_p];
          w_gnt_instr = commit_instr_i[instr_width_p*c +: instr_width_p];
        end
      end
    end
  end

  always_comb begin
    w_fin_any  = |w_fin;
    w_fin_id   = '0;
    w_fin_data = '0;
    for (int c = num_core_p - 1; c >= 0; c--) begin
      if (w_fin[c]) begin
        w_fin_id   = core_w_lp'(c);
        w_fin_data = store_data_i[dword_width_p*c +: 32];
      end
    end
  end

  assign w_unused = ^store_data_i;

  assign trace_v_o  = (r_wr_ptr != r_rd_ptr);
  assign w_occ      = r_wr_ptr - r_rd_ptr;
  assign w_deq      = trace_v_o && trace_ready_i;
  assign w_full     = (w_occ == (ptr_w_lp + 1)'(fifo_els_p)) && !w_deq;
  assign w_enq      = w_gnt_v && !w_full;
  assign w_drop_inc = w_enq ? (w_req_cnt - cnt_width_p'(1)) : w_req_cnt;
  assign w_drop_sum = {1'b0, r_drop} + {1'b0, w_drop_inc};

  assign w_wd_hit = !r_done && (|r_booted) && !(|w_cmt)
                    && (r_wd == wd_w_lp'(watchdog_cycles_p - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_warm      <= '0;
      r_booted    <= '0;
      r_rr_ptr    <= '0;
      r_drop      <= '0;
      r_wd        <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
      r_test_num  <= '0;
      r_done_core <= '0;
      for (int c = 0; c < num_core_p; c++) begin
        r_cmt[c] <= '0;
        r_bub[c] <= '0;
      end
    end else begin
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
      r_booted <= r_booted | w_boot;
      for (int c = 0; c < num_core_p; c++) begin
        if (w_cmt[c] && (r_cmt[c] != '1)) r_cmt[c] <= r_cmt[c] + 1'b1;
        if (w_bub[c] && (r_bub[c] != '1)) r_bub[c] <= r_bub[c] + 1'b1;
      end
      if (w_gnt_v)
        r_rr_ptr <= (w_gnt_id == core_w_lp'(num_core_p - 1)) ? '0 : w_gnt_id + 1'b1;
      r_drop <= w_drop_sum[cnt_width_p] ? '1 : w_drop_sum[cnt_width_p-1:0];
      if (|w_cmt) r_wd <= '0;
      else if (!r_done && (|r_booted)) r_wd <= r_wd + 1'b1;
      if (w_fin_any) begin
        r_done      <= 1'b1;
        r_pass      <= (w_fin_data[31:16] == 16'h0000);
        r_fail      <= (w_fin_data[31:16] == 16'hFFFF);
        r_err       <= (w_fin_data[31:16] != 16'h0000) && (w_fin_data[31:16] != 16'hFFFF);
        r_test_num  <= w_fin_data[15:0];
        r_done_core <= w_fin_id;
      end else if (w_wd_hit) begin
        r_done    <= 1'b1;
        r_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < fifo_els_p; i++) begin
        r_mem_core[i]  <= '0;
        r_mem_kind[i]  <= '0;
        r_mem_pc[i]    <= '0;
        r_mem_instr[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_mem_core[r_wr_ptr[ptr_w_lp-1:0]]  <= w_gnt_id;
        r_mem_kind[r_wr_ptr[ptr_w_lp-1:0]]  <= w_gnt_kind;
        r_mem_pc[r_wr_ptr[ptr_w_lp-1:0]]    <= w_gnt_pc;
        r_mem_instr[r_wr_ptr[ptr_w_lp-1:0]] <= w_gnt_instr;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign trace_core_o  = r_mem_core[r_rd_ptr[ptr_w_lp-1:0]];
  assign trace_kind_o  = r_mem_kind[r_rd_ptr[ptr_w_lp-1:0]];
  assign trace_pc_o    = r_mem_pc[r_rd_ptr[ptr_w_lp-1:0]];
  assign trace_instr_o = r_mem_instr[r_rd_ptr[ptr_w_lp-1:0]];

  always_comb begin
    cmt_cnt_o = '0;
    bub_cnt_o = '0;
    for (int c = 0; c < num_core_p; c++) begin
      cmt_cnt_o[cnt_width_p*c +: cnt_width_p] = r_cmt[c];
      bub_cnt_o[cnt_width_p*c +: cnt_width_p] = r_bub[c];
    end
  end

  assign drop_cnt_o  = r_drop;
  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign fail_o      = r_fail;
  assign err_o       = r_err;
  assign timeout_o   = r_timeout;
  assign test_num_o  = r_test_num;
  assign done_core_o = r_done_core;

endmodule

// File: tb/tb_bp_be_commit_monitor.sv
// Directed bench for bp_be_commit_monitor; a second instance with a short
// watchdog period covers the timeout behaviour.
module tb_bp_be_commit_monitor;
  localparam int NC = 2, VA = 39, IW = 32, DW = 64, CW = 32;
  localparam logic [63:0] FIN = 64'hC00DEAD0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NC-1:0]     cv, sv;
  logic [3*NC-1:0]   ck;
  logic [VA*NC-1:0]  cpc;
  logic [IW*NC-1:0]  cins;
  logic [DW*NC-1:0]  sa, sd;
  logic              rdy;

  logic              tv, done, pass, fail, err, tmo;
  logic [0:0]        tcore, dcore;
  logic [2:0]        tkind;
  logic [VA-1:0]     tpc;
  logic [IW-1:0]     tins;
  logic [CW*NC-1:0]  cmt, bub;
  logic [CW-1:0]     drop;
  logic [15:0]       tnum;

  logic              w_tv, w_done, w_pass, w_fail, w_err, w_tmo;
  logic [0:0]        w_tcore, w_dcore;
  logic [2:0]        w_tkind;
  logic [VA-1:0]     w_tpc;
  logic [IW-1:0]     w_tins;
  logic [CW*NC-1:0]  w_cmt, w_bub;
  logic [CW-1:0]     w_drop;
  logic [15:0]       w_tnum;

  int total = 0;
  int bad   = 0;

  bp_be_commit_monitor #(.num_core_p(NC), .fifo_els_p(8), .watchdog_cycles_p(1024)) u_dut (
    .clk_i(clk), .reset_i(rst), .commit_v_i(cv), .commit_kind_i(ck), .commit_pc_i(cpc),
    .commit_instr_i(cins), .store_v_i(sv), .store_addr_i(sa), .store_data_i(sd),
    .trace_v_o(tv), .trace_ready_i(rdy), .trace_core_o(tcore), .trace_kind_o(tkind),
    .trace_pc_o(tpc), .trace_instr_o(tins), .cmt_cnt_o(cmt), .bub_cnt_o(bub),
    .drop_cnt_o(drop), .done_o(done), .pass_o(pass), .fail_o(fail), .err_o(err),
    .timeout_o(tmo), .test_num_o(tnum), .done_core_o(dcore));

  bp_be_commit_monitor #(.num_core_p(NC), .fifo_els_p(8), .watchdog_cycles_p(16)) u_wd (
    .clk_i(clk), .reset_i(rst), .commit_v_i(cv), .commit_kind_i(ck), .commit_pc_i(cpc),
    .commit_instr_i(cins), .store_v_i(sv), .store_addr_i(sa), .store_data_i(sd),
    .trace_v_o(w_tv), .trace_ready_i(rdy), .trace_core_o(w_tcore), .trace_kind_o(w_tkind),
    .trace_pc_o(w_tpc), .trace_instr_o(w_tins), .cmt_cnt_o(w_cmt), .bub_cnt_o(w_bub),
    .drop_cnt_o(w_drop), .done_o(w_done), .pass_o(w_pass), .fail_o(w_fail), .err_o(w_err),
    .timeout_o(w_tmo), .test_num_o(w_tnum), .done_core_o(w_dcore));

  task automatic clr_in();
    cv = '0; ck = '0; cpc = '0; cins = '0; sv = '0; sa = '0; sd = '0;
  endtask

  task automatic evt(input int c, input logic [2:0] k, input logic [VA-1:0] pc);
    cv[c] = 1'b1;
    ck[3*c +: 3] = k;
    cpc[VA*c +: VA] = pc;
    cins[IW*c +: IW] = pc[31:0] ^ 32'h0000_0013;
  endtask

  task automatic st(input int c, input logic [63:0] a, input logic [63:0] d);
    sv[c] = 1'b1;
    sa[DW*c +: DW] = a;
    sd[DW*c +: DW] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rdy = 1'b0;
    rst = 1'b1;
    #12;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic warm();
    repeat (3) step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (tv !== 1'b0) begin bad++; $display("FAIL rst_tv: got %0h exp 0", tv); end
    total++; if (cmt !== '0) begin bad++; $display("FAIL rst_cmt: got %0h exp 0", cmt); end
    total++; if (bub !== '0) begin bad++; $display("FAIL rst_bub: got %0h exp 0", bub); end
    total++; if (drop !== '0) begin bad++; $display("FAIL rst_drop: got %0h exp 0", drop); end
    total++; if ({done, pass, fail, err, tmo} !== 5'b0) begin bad++; $display("FAIL rst_status: got %b exp 00000", {done, pass, fail, err, tmo}); end
    total++; if ({tnum, dcore, tcore, tkind, tpc, tins} !== '0) begin bad++; $display("FAIL rst_fields: got nonzero exp 0"); end
  endtask

  task automatic test_warmup_boot();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clr_in(); evt(0, 3'd4, 39'h100); step();
    end
    clr_in(); evt(0, 3'd0, 39'h8000_0000); step(); clr_in();
    total++; if (bub[31:0] !== 32'd0) begin bad++; $display("FAIL boot_bub: got %0d exp 0", bub[31:0]); end
    total++; if (cmt[31:0] !== 32'd1) begin bad++; $display("FAIL boot_cmt: got %0d exp 1", cmt[31:0]); end
    total++; if (tv !== 1'b1 || tcore !== 1'b0 || tkind !== 3'd0) begin bad++; $display("FAIL boot_rec_hdr: got v=%0b core=%0d kind=%0d exp 1/0/0", tv, tcore, tkind); end
    total++; if (tpc !== 39'h8000_0000) begin bad++; $display("FAIL boot_rec_pc: got %0h exp 80000000", tpc); end
    total++; if (tins !== 32'h8000_0013) begin bad++; $display("FAIL boot_rec_instr: got %0h exp 80000013", tins); end
    evt(0, 3'd5, 39'h104); step(); clr_in();
    total++; if (bub[31:0] !== 32'd1) begin bad++; $display("FAIL bub_booted: got %0d exp 1", bub[31:0]); end
    evt(0, 3'd7, 39'h108); step(); clr_in();
    total++; if (bub[31:0] !== 32'd1 || cmt[31:0] !== 32'd1 || drop !== 32'd0) begin bad++; $display("FAIL kind7_ignored: got bub=%0d cmt=%0d drop=%0d exp 1/1/0", bub[31:0], cmt[31:0], drop); end
    rdy = 1'b1; step(); rdy = 1'b0;
    total++; if (tv !== 1'b0) begin bad++; $display("FAIL boot_one_rec: got v=%0b exp 0", tv); end
  endtask

  task automatic test_arbitration();
    logic [VA-1:0] exp_pc;
    do_reset(); warm(); rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clr_in();
      evt(0, 3'd0, 39'h100 + 39'(i));
      evt(1, 3'd0, 39'h200 + 39'(i));
      step();
      exp_pc = ((i % 2) == 1) ? 39'h200 + 39'(i) : 39'h100 + 39'(i);
      total++; if (tv !== 1'b1 || tcore !== 1'((i % 2)) || tpc !== exp_pc) begin bad++; $display("FAIL arb_grant%0d: got core=%0d pc=%0h exp core=%0d pc=%0h", i, tcore, tpc, i % 2, exp_pc); end
    end
    clr_in();
    total++; if (drop !== 32'd4) begin bad++; $display("FAIL arb_drop: got %0d exp 4", drop); end
    total++; if (cmt !== {32'd4, 32'd4}) begin bad++; $display("FAIL arb_cmt: got %0h exp 4/4", cmt); end
    step();
    total++; if (tv !== 1'b0) begin bad++; $display("FAIL arb_drained: got v=%0b exp 0", tv); end
    rdy = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset(); warm(); rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clr_in(); evt(1, 3'd0, 39'h1000 + 39'(4 * i)); step();
    end
    clr_in();
    total++; if (drop !== 32'd2) begin bad++; $display("FAIL bp_drop: got %0d exp 2", drop); end
    total++; if (cmt[63:32] !== 32'd10) begin bad++; $display("FAIL bp_cmt1: got %0d exp 10", cmt[63:32]); end
    total++; if (tv !== 1'b1 || tcore !== 1'b1 || tpc !== 39'h1000) begin bad++; $display("FAIL bp_head: got v=%0b core=%0d pc=%0h exp 1/1/1000", tv, tcore, tpc); end
    step(); step();
    total++; if (tv !== 1'b1 || tpc !== 39'h1000) begin bad++; $display("FAIL bp_stable: got v=%0b pc=%0h exp 1/1000", tv, tpc); end
    rdy = 1'b1; evt(0, 3'd0, 39'h7000); step(); clr_in();
    total++; if (drop !== 32'd2 || cmt[31:0] !== 32'd1) begin bad++; $display("FAIL bp_full_deq_enq: got drop=%0d cmt0=%0d exp 2/1", drop, cmt[31:0]); end
    for (int i = 1; i < 8; i++) begin
      total++; if (tv !== 1'b1 || tcore !== 1'b1 || tpc !== 39'h1000 + 39'(4 * i)) begin bad++; $display("FAIL bp_order%0d: got core=%0d pc=%0h exp 1/%0h", i, tcore, tpc, 39'h1000 + 39'(4 * i)); end
      step();
    end
    total++; if (tv !== 1'b1 || tcore !== 1'b0 || tpc !== 39'h7000) begin bad++; $display("FAIL bp_last: got core=%0d pc=%0h exp 0/7000", tcore, tpc); end
    step();
    total++; if (tv !== 1'b0) begin bad++; $display("FAIL bp_empty: got v=%0b exp 0", tv); end
    rdy = 1'b0;
  endtask

  task automatic test_pass_fail();
    logic [63:0] pf_data [3];
    logic [15:0] pf_num  [3];
    pf_data[0] = 64'h0000_0005; pf_num[0] = 16'd5;
    pf_data[1] = 64'hFFFF_0003; pf_num[1] = 16'd3;
    pf_data[2] = 64'h1234_0000; pf_num[2] = 16'd0;
    for (int i = 0; i < 3; i++) begin
      do_reset(); warm(); rdy = 1'b0;
      evt(1, 3'd0, 39'h2000); st(1, FIN, pf_data[i]); step(); clr_in();
      total++; if (done !== 1'b1 || {pass, fail, err} !== (3'b100 >> i) || tmo !== 1'b0) begin bad++; $display("FAIL fin%0d_status: got done=%0b pfe=%b exp 1/%b", i, done, {pass, fail, err}, 3'b100 >> i); end
      total++; if (tnum !== pf_num[i] || dcore !== 1'b1) begin bad++; $display("FAIL fin%0d_num: got num=%0d core=%0d exp %0d/1", i, tnum, dcore, pf_num[i]); end
      total++; if (cmt[63:32] !== 32'd1 || tv !== 1'b1 || tcore !== 1'b1 || tpc !== 39'h2000) begin bad++; $display("FAIL fin%0d_traced: got cmt1=%0d v=%0b core=%0d pc=%0h exp 1/1/1/2000", i, cmt[63:32], tv, tcore, tpc); end
      evt(0, 3'd0, 39'h3000); evt(1, 3'd4, 39'h3004); step(); clr_in();
      total++; if (cmt[31:0] !== 32'd0 || bub[63:32] !== 32'd0 || drop !== 32'd0) begin bad++; $display("FAIL fin%0d_frozen: got cmt0=%0d bub1=%0d drop=%0d exp 0/0/0", i, cmt[31:0], bub[63:32], drop); end
      rdy = 1'b1; step(); rdy = 1'b0;
      total++; if (tv !== 1'b0) begin bad++; $display("FAIL fin%0d_drain: got v=%0b exp 0", i, tv); end
    end
    do_reset(); warm();
    evt(0, 3'd0, 39'h10); st(0, FIN + 64'd8, 64'h0); step(); clr_in();
    evt(0, 3'd1, 39'h14); st(0, FIN, 64'h0); step(); clr_in();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL fin_non_match: got done=%0b exp 0", done); end
    evt(0, 3'd0, 39'h18); st(0, FIN, 64'h0000_0009);
    evt(1, 3'd0, 39'h1C); st(1, FIN, 64'hFFFF_0003); step(); clr_in();
    total++; if (pass !== 1'b1 || fail !== 1'b0 || tnum !== 16'd9 || dcore !== 1'b0) begin bad++; $display("FAIL fin_lowest: got pass=%0b fail=%0b num=%0d core=%0d exp 1/0/9/0", pass, fail, tnum, dcore); end
  endtask

  task automatic test_watchdog();
    do_reset(); warm(); rdy = 1'b1;
    evt(0, 3'd0, 39'h4000); step(); clr_in();
    repeat (15) step();
    total++; if (w_tmo !== 1'b0 || w_done !== 1'b0) begin bad++; $display("FAIL wd_early: got tmo=%0b done=%0b exp 0/0", w_tmo, w_done); end
    step();
    total++; if (w_tmo !== 1'b1 || w_done !== 1'b1 || {w_pass, w_fail, w_err} !== 3'b000) begin bad++; $display("FAIL wd_hit: got tmo=%0b done=%0b pfe=%b exp 1/1/000", w_tmo, w_done, {w_pass, w_fail, w_err}); end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL wd_long_period: got tmo=%0b exp 0", tmo); end
    evt(0, 3'd0, 39'h4004); step(); clr_in();
    total++; if (w_cmt[31:0] !== 32'd1) begin bad++; $display("FAIL wd_frozen: got cmt0=%0d exp 1", w_cmt[31:0]); end
    do_reset(); warm(); rdy = 1'b1;
    evt(0, 3'd0, 39'h4100); step(); clr_in();
    repeat (14) step();
    evt(0, 3'd0, 39'h4104); step(); clr_in();
    repeat (15) step();
    total++; if (w_tmo !== 1'b0) begin bad++; $display("FAIL wd_restart_early: got tmo=%0b exp 0", w_tmo); end
    step();
    total++; if (w_tmo !== 1'b1) begin bad++; $display("FAIL wd_restart_hit: got tmo=%0b exp 1", w_tmo); end
    rdy = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset(); warm(); rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      clr_in(); evt(0, 3'd0, 39'h5000 + 39'(i)); evt(1, 3'd0, 39'h6000 + 39'(i)); step();
    end
    clr_in();
    total++; if (tv !== 1'b1 || drop !== 32'd5 || cmt !== {32'd5, 32'd5}) begin bad++; $display("FAIL ar_pre: got v=%0b drop=%0d cmt=%0h exp 1/5/5,5", tv, drop, cmt); end
    #3 rst = 1'b1;
    #1;
    total++; if (tv !== 1'b0) begin bad++; $display("FAIL ar_tv: got %0b exp 0", tv); end
    total++; if (cmt !== '0 || bub !== '0 || drop !== '0 || tpc !== '0) begin bad++; $display("FAIL ar_counts: got cmt=%0h drop=%0d pc=%0h exp 0", cmt, drop, tpc); end
    @(posedge clk); #1; rst = 1'b0;
    evt(0, 3'd0, 39'h5100); step(); clr_in();
    total++; if (cmt !== '0 || tv !== 1'b0) begin bad++; $display("FAIL ar_warm_restart: got cmt=%0h v=%0b exp 0/0", cmt, tv); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr_in();
    rdy = 1'b0;
    rst = 1'b1;
    test_reset();
    test_warmup_boot();
    test_arbitration();
    test_backpressure();
    test_pass_fail();
    test_watchdog();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_be_commit_monitor.md
# bp_be_commit_monitor

Synthesizable, multi-core commit-trace monitor for the BE test harness: the successor to the single-core display-only tracer. Takes per-core commit events and classifies them; counts commits and bubbles per core; detects pass/fail stores to the finish address; runs a no-progress watchdog; funnels records through a round-robin arbiter into a bounded FIFO drained by a valid/ready consumer (host DPI bridge or FPGA trace link).

## Interface
- num_core_p, 2, number of commit channels
- vaddr_width_p, 39, PC width
- instr_width_p, 32, instruction width
- dword_width_p, 64, store address/data width
- cnt_width_p, 32, width of each per-core counter
- fifo_els_p, 8, trace FIFO depth (power of two, ≥2)
- watchdog_cycles_p, 1024, idle cycles before timeout
- finish_addr_p, 64'hC00DEAD0, pass/fail store address
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- commit_v_i  in  num_core_p  event valid per core
- commit_kind_i  in  3*num_core_p  0 CMT, 1 MIS, 2 ROL, 3 PSN, 4 BUB_FE, 5 BUB_BE, 6 BUB_ME, 7 reserved
- commit_pc_i  in  vaddr_width_p*num_core_p  PC
- commit_instr_i  in  instr_width_p*num_core_p  instruction
- store_v_i  in  num_core_p  committing instruction is a store (meaningful only with kind CMT)
- store_addr_i  in  dword_width_p*num_core_p  effective address (rs1+imm)
- store_data_i  in  dword_width_p*num_core_p  rs2 value
- trace_v_o  out  1  FIFO head valid
- trace_ready_i  in  1  consumer accepts head
- trace_core_o  out  clog2(num_core_p)  head core id
- trace_kind_o  out  3  head kind
- trace_pc_o  out  vaddr_width_p  head PC
- trace_instr_o  out  instr_width_p  head instruction
- cmt_cnt_o  out  cnt_width_p*num_core_p  CMT count per core
- bub_cnt_o  out  cnt_width_p*num_core_p  bubble count per core (all three causes)
- drop_cnt_o  out  cnt_width_p  records lost to arbitration or a full FIFO
- done_o, pass_o, fail_o, err_o, timeout_o  out  1 each  sticky status
- test_num_o  out  16  test number from the finish store
- done_core_o  out  clog2(num_core_p)  core that finished

## Operation
- Warm-up: a 2-bit counter runs for 3 cycles after reset deasserts. All inputs are ignored until it saturates at 3.
- Boot: per-core booted flag, set by that core's first event of kind 0–3. Bubbles from an unbooted core are not counted.
- Classification (commit_v_i=1, warm-up done, done_o=0):
  - kinds 0–3 are trace records;
  - kinds 4–6 increment bub_cnt (booted cores only) and produce no record;
  - kind 7 is ignored entirely.
- Counters: kind 0 increments cmt_cnt. All counters saturate at all-ones.
- Arbitration: at most one record enqueues per cycle.
  - Round-robin among requesting cores; the pointer moves to one past the granted core.
  - Every non-granted request increments drop_cnt by 1 (multiple drops in one cycle add their count).
  - A granted record that finds the FIFO full is also dropped and counted.
- FIFO full test: occupancy == fifo_els_p after accounting for a same-cycle dequeue. Enqueue into a full FIFO therefore succeeds when trace_ready_i=1 in that cycle.
- Finish detection: kind CMT with store_v=1 and store_addr == finish_addr_p.
  - store_data[31:16] == 16'h0000 sets pass_o.
  - store_data[31:16] == 16'hFFFF sets fail_o.
  - Any other value sets err_o.
  - All three cases set done_o, latch test_num_o = store_data[15:0], and latch done_core_o.
  - If several cores finish in the same cycle, the lowest index wins.
  - The finish store is itself traced and counted.
- After done_o: no new records, counts or drops. The FIFO keeps draining.
- Watchdog:
  - Armed once any core is booted.
  - The counter clears on any accepted kind 0 event and otherwise increments.
  - At watchdog_cycles_p it sets timeout_o and done_o (pass/fail/err stay 0), then freezes.

## Timing
- Reset: all outputs 0. This includes trace_v_o, the FIFO contents and pointers, the arbiter pointer (core 0), the booted flags and the warm-up counter.
- Counters and status update on the edge after the event (latency 1).
- Record latency: an event at edge t is visible on trace_* after edge t+1 if the FIFO was empty.
- The FIFO head changes only on trace_v_o & trace_ready_i. trace_* stays stable while trace_v_o=1 and trace_ready_i=0.
- Reset asserted mid-operation clears everything asynchronously. Warm-up restarts on deassertion.
- Pointer wrap: log2(fifo_els_p) index bits plus one wrap bit.

## Test plan
- Warm-up/boot: reset, then core0 kind 4 for 5 cycles, then kind 0 at PC 0x80000000 → bub_cnt[0]=0, cmt_cnt[0]=1, one record {core 0, CMT, 0x80000000}.
- Arbitration: both cores send kind 0 for 4 consecutive cycles with trace_ready_i=1 → grants alternate 0,1,0,1; drop_cnt=4; cmt_cnt=4/4.
- Backpressure: fifo_els_p=8, trace_ready_i=0, core1 sends 10 CMT → 8 records held, drop_cnt=2, cmt_cnt[1]=10. Raising ready drains records in order with stable payloads.
- Pass/fail: core1 stores 0x0000_0005 to 0xC00DEAD0 → pass_o=1, test_num_o=5, done_core_o=1, later events ignored. Repeat with 0xFFFF_0003 → fail_o=1, test_num=3. Repeat with 0x1234_0000 → err_o=1.
- Watchdog: watchdog_cycles_p=16, one CMT followed by idle → timeout_o=1 and done_o=1 exactly 16 cycles after the commit. A commit at cycle 15 restarts the count.
- Async reset mid-run: assert reset_i between edges with the FIFO at 5 entries → trace_v_o=0 immediately, and all counters read 0.
